// File: rtl/pic_ram_writer.sv
// pic_ram_writer
//   Frame-buffer writer for the picture RAM that the VGA path scans out.
//   It takes a raster-ordered RGB888 pixel stream over a valid/ready
//   handshake and finds frame and line boundaries from the s_sof and s_eol
//   markers. Each pixel is written at a linear address from 0 to
//   WIDTH*HEIGHT-1.
//
// Ports
//   sys_clk      sole clock
//   sys_rst      synchronous, active-high reset
//   s_valid      source beat valid
//   s_ready      writer can accept a beat; low only while wr_hold is high
//   s_data       pixel data (RGB888)
//   s_sof        beat is the first pixel of a frame
//   s_eol        beat is the last pixel of a line
//   wr_hold      RAM write port is unavailable this cycle
//   ram_wr_en    write strobe, one cycle per written pixel
//   ram_wr_addr  write address; holds its last value while ram_wr_en is low
//   ram_wr_data  write data; holds its last value while ram_wr_en is low
//   frame_done   one-cycle pulse, issued with the write of the final pixel
//   frame_err    one-cycle pulse on a framing violation
//   frame_cnt    number of completed frames, wraps from 255 to 0
//   busy         high while a frame is being written
module pic_ram_writer #(
    parameter int WIDTH  = 350,
    parameter int HEIGHT = 350,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 24
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic              s_eol,
    input  logic              wr_hold,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        frame_cnt,
    output logic              busy
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [XW-1:0]     X_LAST = XW'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    // Counter values after the first pixel of a frame. A one-pixel-wide
    // picture wraps to the next line right away.
    localparam logic [XW-1:0] X_FIRST = (WIDTH == 1) ? '0 : XW'(1);
    localparam logic [YW-1:0] Y_FIRST = (WIDTH == 1) ? YW'(1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FLUSH
    } state_t;

    state_t            state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;

    logic accept;
    logic eol_ok;

    assign s_ready = !wr_hold;
    assign accept  = s_valid && s_ready;
    // The line marker must appear on the last column, and only there.
    assign eol_ok  = (s_eol == (x == X_LAST));
    assign busy    = (state == WRITE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            addr        <= '0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            ram_wr_en  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (accept) begin
                if (s_sof) begin
                    // A start of frame always restarts at address 0. This
                    // holds in every state. In WRITE it is a resync, and it
                    // takes priority over both the eol check and the
                    // completion of the frame.
                    ram_wr_en   <= 1'b1;
                    ram_wr_addr <= '0;
                    ram_wr_data <= s_data;
                    frame_err   <= (state == WRITE);
                    x           <= X_FIRST;
                    y           <= Y_FIRST;
                    addr        <= ADDR_W'(1);
                    state       <= WRITE;
                end else if (state == WRITE) begin
                    if (!eol_ok) begin
                        // Drop the bad beat and wait for the next frame.
                        frame_err <= 1'b1;
                        x         <= '0;
                        y         <= '0;
                        addr      <= '0;
                        state     <= FLUSH;
                    end else begin
                        ram_wr_en   <= 1'b1;
                        ram_wr_addr <= addr;
                        ram_wr_data <= s_data;
                        if (addr == A_LAST) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                            x          <= '0;
                            y          <= '0;
                            addr       <= '0;
                            state      <= IDLE;
                        end else begin
                            addr <= addr + ADDR_W'(1);
                            if (x == X_LAST) begin
                                x <= '0;
                                y <= y + YW'(1);
                            end else begin
                                x <= x + XW'(1);
                            end
                        end
                    end
                end
                // In IDLE and FLUSH, beats without s_sof are dropped silently.
            end
        end
    end

endmodule

// File: tb/tb_pic_ram_writer.sv
module tb_pic_ram_writer;

    localparam int W      = 4;
    localparam int H      = 3;
    localparam int NPIX   = W * H;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 24;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data  = '0;
    logic              s_sof   = 1'b0;
    logic              s_eol   = 1'b0;
    logic              wr_hold = 1'b0;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              frame_done;
    logic              frame_err;
    logic [7:0]        frame_cnt;
    logic              busy;

    pic_ram_writer #(
        .WIDTH (W),
        .HEIGHT(H),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .s_eol      (s_eol),
        .wr_hold    (wr_hold),
        .ram_wr_en  (ram_wr_en),
        .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Stimulus knobs
    bit rand_gaps = 0;
    bit rand_hold = 0;
    int hold_force = 0;
    bit rst_req = 1;

    // Reference model. It tracks the frame as "in frame at pixel index pos",
    // "waiting for sof" or "flushing", and predicts the registered outputs.
    int unsigned m_mode = 0;   // 0 waiting, 1 in frame, 2 flushing
    int unsigned m_pos  = 0;
    int unsigned e_en = 0, e_addr = 0, e_data = 0, e_done = 0, e_err = 0, e_cnt = 0;

    // Log of writes that the DUT performed
    int lg_addr[$];
    int lg_data[$];
    int lg_cyc[$];
    int lg_done[$];
    int lg_err[$];
    int err_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_step();
        if (sys_rst) begin
            m_mode = 0; m_pos = 0;
            e_en = 0; e_addr = 0; e_data = 0; e_done = 0; e_err = 0; e_cnt = 0;
            return;
        end
        e_en = 0; e_done = 0; e_err = 0;
        if (s_valid && !wr_hold) begin
            if (s_sof) begin
                if (m_mode == 1) e_err = 1;
                e_en = 1; e_addr = 0; e_data = s_data;
                m_pos = 1; m_mode = 1;
            end else if (m_mode == 1) begin
                if (s_eol != ((m_pos % W) == W - 1)) begin
                    e_err = 1; m_mode = 2;
                end else begin
                    e_en = 1; e_addr = m_pos; e_data = s_data;
                    if (m_pos == NPIX - 1) begin
                        e_done = 1; e_cnt = (e_cnt + 1) % 256; m_mode = 0; m_pos = 0;
                    end else begin
                        m_pos++;
                    end
                end
            end
        end
    endfunction

    // One clock cycle. The inputs are already applied. The model predicts the
    // outputs, then the DUT is compared at the falling edge and writes are logged.
    task automatic drive_cycle(input bit v, input int d, input bit sof, input bit eol, output bit acc);
        s_valid = v; s_data = DATA_W'(d); s_sof = sof; s_eol = eol;
        sys_rst = rst_req;
        if (hold_force > 0) begin
            wr_hold = 1; hold_force--;
        end else begin
            wr_hold = rand_hold ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        acc = v && !wr_hold && !rst_req;
        model_step();
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
        chk("s_ready", s_ready, !wr_hold);
        chk("ram_wr_en", ram_wr_en, e_en);
        chk("ram_wr_addr", ram_wr_addr, e_addr);
        chk("ram_wr_data", ram_wr_data, e_data);
        chk("frame_done", frame_done, e_done);
        chk("frame_err", frame_err, e_err);
        chk("frame_cnt", frame_cnt, e_cnt);
        chk("busy", busy, m_mode == 1);
        if (frame_err === 1'b1) err_seen++;
        if (ram_wr_en === 1'b1) begin
            lg_addr.push_back(int'(ram_wr_addr));
            lg_data.push_back(int'(ram_wr_data));
            lg_cyc.push_back(cyc);
            lg_done.push_back(int'(frame_done));
            lg_err.push_back(int'(frame_err));
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, a);
    endtask

    task automatic send_beat(input int d, input bit sof, input bit eol);
        bit a;
        bit done;
        done = 0;
        if (rand_gaps) idle($urandom_range(0, 2));
        for (int i = 0; i < 50 && !done; i++) begin
            drive_cycle(1, d, sof, eol, a);
            done = a;
        end
        if (!done) chk("beat_accept_timeout", 0, 1);
    endtask

    // Beats k0..k1-1 of a frame with correct markers, data = base + k
    task automatic send_pixels(input int k0, input int k1, input int base);
        for (int k = k0; k < k1; k++)
            send_beat(base + k, k == 0, (k % W) == W - 1);
    endtask

    task automatic clear_log();
        lg_addr.delete(); lg_data.delete(); lg_cyc.delete();
        lg_done.delete(); lg_err.delete();
        err_seen = 0;
    endtask

    // Log entries from first onward must hold one complete frame, data = base + addr
    task automatic check_frame(input int first, input int base, input bit consecutive);
        chk("log_size", lg_addr.size(), first + NPIX);
        if (lg_addr.size() == first + NPIX) begin
            for (int i = 0; i < NPIX; i++) begin
                chk("log_addr", lg_addr[first + i], i);
                chk("log_data", lg_data[first + i], base + i);
                chk("log_done", lg_done[first + i], (i == NPIX - 1) ? 1 : 0);
                if (consecutive)
                    chk("log_cyc", lg_cyc[first + i], lg_cyc[first] + i);
            end
        end
    endtask

    initial begin
        bit a;
        int gpos;
        int sof_b, eol_b;

        // Reset
        rst_req = 1;
        idle(2);
        chk("rst_wr_en", ram_wr_en, 0);
        chk("rst_addr", ram_wr_addr, 0);
        chk("rst_data", ram_wr_data, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 0);
        rst_req = 0;
        idle(2);

        // 1: continuous frame, data = index
        clear_log();
        send_pixels(0, NPIX, 0);
        idle(2);
        check_frame(0, 0, 1);
        chk("t1_cnt", frame_cnt, 1);
        chk("t1_busy", busy, 0);

        // 2: wr_hold for 3 cycles mid-line plus random valid gaps
        clear_log();
        rand_gaps = 1;
        send_pixels(0, 2, 100);
        hold_force = 3;
        send_pixels(2, NPIX, 100);
        rand_gaps = 0;
        idle(2);
        check_frame(0, 100, 0);
        chk("t2_cnt", frame_cnt, 2);

        // 3: beats without sof in IDLE are dropped
        clear_log();
        for (int k = 0; k < 5; k++) send_beat(50 + k, 0, k == 3);
        idle(1);
        chk("t3_nowrite", lg_addr.size(), 0);
        send_pixels(0, NPIX, 200);
        idle(2);
        check_frame(0, 200, 1);
        chk("t3_cnt", frame_cnt, 3);

        // 4: early eol on x=2
        clear_log();
        send_pixels(0, 2, 300);
        send_beat(302, 0, 1);
        idle(1);
        chk("t4_written", lg_addr.size(), 2);
        chk("t4_err", err_seen, 1);
        chk("t4_busy", busy, 0);
        for (int k = 0; k < 3; k++) send_beat(77, 0, k == 1);
        idle(1);
        chk("t4_flushed", lg_addr.size(), 2);
        send_pixels(0, NPIX, 400);
        idle(2);
        check_frame(2, 400, 1);
        chk("t4_cnt", frame_cnt, 4);

        // 5: sof on beat 6 of a frame, then resync
        clear_log();
        send_pixels(0, 6, 500);
        send_pixels(0, NPIX, 600);
        idle(2);
        check_frame(6, 600, 1);
        chk("t5_err_with_addr0", lg_err[6], 1);
        chk("t5_err_count", err_seen, 1);
        chk("t5_cnt", frame_cnt, 5);

        // 6: reset after 7 beats
        clear_log();
        send_pixels(0, 7, 700);
        rst_req = 1;
        idle(1);
        rst_req = 0;
        chk("t6_wr_en", ram_wr_en, 0);
        chk("t6_addr", ram_wr_addr, 0);
        chk("t6_data", ram_wr_data, 0);
        chk("t6_done", frame_done, 0);
        chk("t6_err", frame_err, 0);
        chk("t6_cnt", frame_cnt, 0);
        chk("t6_busy", busy, 0);
        clear_log();
        send_pixels(0, NPIX, 800);
        idle(2);
        check_frame(0, 800, 1);
        chk("t6_cnt_after", frame_cnt, 1);

        // Randomized stream with occasional marker errors, resyncs and resets
        rand_gaps = 1;
        rand_hold = 1;
        gpos = 0;
        for (int n = 0; n < 600; n++) begin
            sof_b = (gpos == 0 || $urandom_range(0, 19) == 0) ? 1 : 0;
            if (sof_b == 1) gpos = 0;
            eol_b = (((gpos % W) == W - 1) ^ ($urandom_range(0, 11) == 0)) ? 1 : 0;
            send_beat(int'($urandom_range(0, 32'hFFFFFF)), sof_b[0], eol_b[0]);
            gpos = (gpos + 1) % NPIX;
            if ($urandom_range(0, 149) == 0) begin
                rst_req = 1;
                idle(1);
                rst_req = 0;
                gpos = 0;
            end
        end
        rand_gaps = 0;
        rand_hold = 0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        failures++;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
